// File: rtl/alu_result_arbiter_pkg.sv
// Shared sizes, FSM encoding and index helper for the ALU result-mux arbiter.
// Imported by the interface, the top and its sub-modules.
package alu_result_arbiter_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;
    localparam int DATA_W  = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Round-robin successor; the 3-bit add wraps 7 back to 0.
    function automatic logic [SEL_W-1:0] next_index(input logic [SEL_W-1:0] idx);
        return idx + SEL_W'(1);
    endfunction

endpackage

// File: rtl/alu_result_arbiter_if.sv
// Requester-side and output-side signals of the ALU result-mux arbiter.
// The arbiter uses the slave modport; whoever drives requests uses master.
interface alu_result_arbiter_if;
    import alu_result_arbiter_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        cfg_mask;
    logic [SEL_W-1:0]          sel;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [SEL_W-1:0]          out_src;
    logic                      out_last;
    logic                      out_ready;
    logic                      busy;
    logic                      err_timeout;

    modport master (
        output req_valid, req_last, req_data, cfg_mask, out_ready,
        input  req_ready, sel, out_valid, out_data, out_src, out_last, busy, err_timeout
    );

    modport slave (
        input  req_valid, req_last, req_data, cfg_mask, out_ready,
        output req_ready, sel, out_valid, out_data, out_src, out_last, busy, err_timeout
    );

endinterface

// File: rtl/alu_result_arbiter_rr_pick8.sv
// Combinational round-robin picker: first set candidate bit at or above ptr,
// wrapping modulo 8.
module rr_pick8 import alu_result_arbiter_pkg::*; (
    input  logic [NUM_REQ-1:0] cand,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   index,
    output logic               found
);

    logic [SEL_W-1:0] probe;

    always_comb begin
        index = '0;
        found = 1'b0;
        probe = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && cand[probe]) begin
                found = 1'b1;
                index = probe;
            end
            probe = probe + SEL_W'(1);
        end
    end

endmodule

// File: rtl/alu_result_mux8.sv
// The ALU's 8-to-1 32-bit result mux; lane i of data_in is bits [32i+31:32i].
module alu_result_mux8 import alu_result_arbiter_pkg::*; (
    input  logic [NUM_REQ*DATA_W-1:0] data_in,
    input  logic [SEL_W-1:0]          sel,
    output logic [DATA_W-1:0]         result
);

    logic [DATA_W-1:0] lanes [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign lanes[i] = data_in[i*DATA_W +: DATA_W];
    end

    assign result = lanes[sel];

endmodule

// File: rtl/alu_result_arbiter.sv
// Packet-locked round-robin arbiter for the ALU result mux, with a one-entry
// registered output stage and a watchdog that aborts a stalled owner.
module alu_result_arbiter import alu_result_arbiter_pkg::*; #(
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_result_arbiter_if.slave  bus
);

    localparam bit WD_EN = (TIMEOUT > 0);
    localparam int CNT_W = WD_EN ? $clog2(TIMEOUT + 1) : 1;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   owner_q, owner_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic [SEL_W-1:0]   out_src_q, out_src_d;
    logic               out_last_q, out_last_d;

    logic [NUM_REQ-1:0] cand;
    logic [SEL_W-1:0]   pick_idx;
    logic               pick_found;
    logic [DATA_W-1:0]  mux_data;
    logic [NUM_REQ-1:0] req_ready;
    logic               owner_valid;
    logic               owner_last;
    logic               accept;
    logic               abort;

    assign cand = bus.req_valid & ~bus.cfg_mask;

    rr_pick8 u_pick (
        .cand  (cand),
        .ptr   (ptr_q),
        .index (pick_idx),
        .found (pick_found)
    );

    alu_result_mux8 u_mux (
        .data_in (bus.req_data),
        .sel     (owner_q),
        .result  (mux_data)
    );

    // Only the owner is ever offered ready, and only when the output stage
    // can take a beat this cycle (empty, or draining in the same cycle).
    always_comb begin
        owner_valid = bus.req_valid[owner_q];
        owner_last  = bus.req_last[owner_q];
        req_ready   = '0;
        if (state_q == ST_BUSY) begin
            req_ready[owner_q] = ~out_valid_q | bus.out_ready;
        end
        accept = owner_valid & req_ready[owner_q];
        abort  = 1'b0;
        if (WD_EN && state_q == ST_BUSY && !owner_valid && (int'(cnt_q) + 1 >= TIMEOUT)) begin
            abort = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_BUSY;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                if (accept) begin
                    cnt_d = '0;
                    if (owner_last) begin
                        state_d = ST_IDLE;
                        ptr_d   = next_index(owner_q);
                    end
                end else if (abort) begin
                    state_d = ST_IDLE;
                    ptr_d   = next_index(owner_q);
                    err_d   = 1'b1;
                end else if (WD_EN && !owner_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // An abort leaves the output stage alone so a registered beat still drains.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_last_d  = out_last_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_data;
            out_src_d   = owner_q;
            out_last_d  = owner_last;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.sel         = owner_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_src     = out_src_q;
    assign bus.out_last    = out_last_q;
    assign bus.busy        = (state_q == ST_BUSY);
    assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_alu_result_arbiter.sv
// Bench for alu_result_arbiter: per-requester beat queues, a packet-level
// reference model compared every cycle, and directed literal checks.
module tb_alu_result_arbiter;
    import alu_result_arbiter_pkg::*;

    localparam int TB_TIMEOUT = 4;
    localparam int QDEPTH     = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_result_arbiter_if bus();

    alu_result_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Beats waiting at each requester; head advances on handshake.
    logic [31:0] beat_d [NUM_REQ][QDEPTH];
    logic        beat_l [NUM_REQ][QDEPTH];
    int          head   [NUM_REQ] = '{default: 0};
    int          tail   [NUM_REQ] = '{default: 0};

    // Values seen mid-cycle, used by the driver and model at the next edge.
    logic [7:0]   s_valid  = 8'h00;
    logic [7:0]   s_last   = 8'h00;
    logic [7:0]   s_ready  = 8'h00;
    logic [7:0]   s_mask   = 8'h00;
    logic [255:0] s_data   = '0;
    logic         s_oready = 1'b0;
    logic         s_rst    = 1'b1;

    // Reference model state.
    bit          m_busy  = 1'b0;
    int          m_owner = 0;
    int          m_ptr   = 0;
    int          m_stall = 0;
    bit          m_ov    = 1'b0;
    logic [31:0] m_od    = 32'h0;
    int          m_os    = 0;
    bit          m_ol    = 1'b0;
    bit          m_err   = 1'b0;
    bit          m_acc;
    int          m_pick;

    logic [7:0]   drv_v;
    logic [7:0]   drv_l;
    logic [255:0] drv_d;
    logic [7:0]   exp_ready;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int r, input logic [31:0] d, input logic l);
        beat_d[r][tail[r] % QDEPTH] = d;
        beat_l[r][tail[r] % QDEPTH] = l;
        tail[r]++;
    endtask

    function automatic int pickNext(input logic [7:0] cand, input int start);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (cand[(start + k) % NUM_REQ]) return (start + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // Requester driver: retire handshaken beats, then present queue heads.
    always @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (s_rst) head[i] = tail[i];
            else if (s_valid[i] && s_ready[i]) head[i]++;
        end
        #1;
        drv_v = '0;
        drv_l = '0;
        drv_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (head[i] < tail[i]) begin
                drv_v[i] = 1'b1;
                drv_l[i] = beat_l[i][head[i] % QDEPTH];
                drv_d[i*32 +: 32] = beat_d[i][head[i] % QDEPTH];
            end
        end
        bus.req_valid = drv_v;
        bus.req_last  = drv_l;
        bus.req_data  = drv_d;
    end

    // Packet-level model: one owner per packet, round-robin from the slot after
    // the previous owner, single registered output slot.
    always @(posedge clk) begin
        if (s_rst) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_stall = 0;
            m_ov = 0; m_od = 32'h0; m_os = 0; m_ol = 0; m_err = 0;
        end else begin
            m_acc = m_busy && s_valid[m_owner] && (!m_ov || s_oready);
            m_err = 1'b0;
            if (m_acc) begin
                m_ov = 1'b1;
                m_od = s_data[m_owner*32 +: 32];
                m_os = m_owner;
                m_ol = s_last[m_owner];
            end else if (s_oready) begin
                m_ov = 1'b0;
            end
            if (!m_busy) begin
                m_pick = pickNext(s_valid & ~s_mask, m_ptr);
                if (m_pick >= 0) begin
                    m_busy  = 1'b1;
                    m_owner = m_pick;
                    m_stall = 0;
                end
            end else if (m_acc) begin
                m_stall = 0;
                if (s_last[m_owner]) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_owner + 1) % NUM_REQ;
                end
            end else if (!s_valid[m_owner]) begin
                m_stall++;
                if (m_stall == TB_TIMEOUT) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_owner + 1) % NUM_REQ;
                    m_err  = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, then snapshot for the next edge.
    always @(negedge clk) begin
        exp_ready = 8'h00;
        if (m_busy && (!m_ov || bus.out_ready)) exp_ready[m_owner] = 1'b1;
        checkOutput("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        checkOutput("sel", 32'(bus.sel), 32'(m_owner));
        checkOutput("busy", 32'(bus.busy), 32'(m_busy));
        checkOutput("err_timeout", 32'(bus.err_timeout), 32'(m_err));
        checkOutput("out_valid", 32'(bus.out_valid), 32'(m_ov));
        checkOutput("out_data", bus.out_data, m_od);
        checkOutput("out_src", 32'(bus.out_src), 32'(m_os));
        checkOutput("out_last", 32'(bus.out_last), 32'(m_ol));
        s_valid  = bus.req_valid;
        s_last   = bus.req_last;
        s_data   = bus.req_data;
        s_ready  = bus.req_ready;
        s_mask   = bus.cfg_mask;
        s_oready = bus.out_ready;
        s_rst    = rst;
    end

    int order [3] = '{0, 5, 7};

    initial begin
        bus.out_ready = 1'b1;
        bus.cfg_mask  = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'h00);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_sel", 32'(bus.sel), 32'd0);

        // Single two-beat packet from requester 3
        @(posedge clk); #2;
        rst = 1'b0;
        applyStimulus(3, 32'hA5A5_0001, 1'b0);
        applyStimulus(3, 32'hA5A5_0002, 1'b1);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t1_ready_c1", 32'(bus.req_ready), 32'h08);
        @(negedge clk);
        checkOutput("t1_ready_c2", 32'(bus.req_ready), 32'h08);
        checkOutput("t1_data_c2", bus.out_data, 32'hA5A5_0001);
        checkOutput("t1_src_c2", 32'(bus.out_src), 32'd3);
        checkOutput("t1_last_c2", 32'(bus.out_last), 32'd0);
        @(negedge clk);
        checkOutput("t1_data_c3", bus.out_data, 32'hA5A5_0002);
        checkOutput("t1_last_c3", 32'(bus.out_last), 32'd1);
        checkOutput("t1_ptr", 32'(dut.ptr_q), 32'd4);
        checkOutput("t1_model_ptr", 32'(m_ptr), 32'd4);

        // Round-robin among 0, 5, 7 from reset
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 32'h0000_0100 + k, 1'b1);
            applyStimulus(5, 32'h0000_0500 + k, 1'b1);
            applyStimulus(7, 32'h0000_0700 + k, 1'b1);
        end
        @(posedge clk);
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            if (c % 2 == 1) begin
                checkOutput("t2_grant_sel", 32'(bus.sel), 32'(order[((c - 1) / 2) % 3]));
                checkOutput("t2_grant_busy", 32'(bus.busy), 32'd1);
            end else if (c > 0) begin
                checkOutput("t2_bubble_busy", 32'(bus.busy), 32'd0);
            end
        end
        repeat (8) @(negedge clk);

        // Wrap-around and masking: first park ptr at 7
        applyStimulus(6, 32'h0000_0600, 1'b1);
        @(posedge clk);
        repeat (4) @(negedge clk);
        checkOutput("t3_ptr7", 32'(dut.ptr_q), 32'd7);
        bus.cfg_mask = 8'h80;
        applyStimulus(7, 32'h7777_0001, 1'b1);
        applyStimulus(2, 32'h2222_0001, 1'b0);
        applyStimulus(2, 32'h2222_0002, 1'b0);
        applyStimulus(2, 32'h2222_0003, 1'b1);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t3_sel_c1", 32'(bus.sel), 32'd2);
        @(posedge clk); #2;
        bus.cfg_mask = 8'h00;
        @(negedge clk);
        checkOutput("t3_sel_c2", 32'(bus.sel), 32'd2);
        @(negedge clk);
        checkOutput("t3_sel_c3", 32'(bus.sel), 32'd2);
        checkOutput("t3_src_c3", 32'(bus.out_src), 32'd2);
        @(negedge clk);
        checkOutput("t3_busy_c4", 32'(bus.busy), 32'd0);
        checkOutput("t3_ptr3", 32'(dut.ptr_q), 32'd3);
        @(negedge clk);
        checkOutput("t3_sel7_c5", 32'(bus.sel), 32'd7);
        repeat (3) @(negedge clk);

        // Backpressure on a four-beat packet from requester 1
        for (int k = 1; k <= 4; k++) applyStimulus(1, 32'hB000_0000 + k, (k == 4));
        @(posedge clk);
        @(posedge clk); #2;
        @(posedge clk); #2;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checkOutput("t4_ready_stall_c2", 32'(bus.req_ready), 32'h00);
        checkOutput("t4_data_c2", bus.out_data, 32'hB000_0001);
        repeat (4) @(negedge clk);
        checkOutput("t4_ready_stall_c6", 32'(bus.req_ready), 32'h00);
        checkOutput("t4_data_c6", bus.out_data, 32'hB000_0001);
        checkOutput("t4_err_c6", 32'(bus.err_timeout), 32'd0);
        @(posedge clk); #2;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("t4_ready_c7", 32'(bus.req_ready), 32'h02);
        @(negedge clk);
        checkOutput("t4_data_c8", bus.out_data, 32'hB000_0002);
        @(negedge clk);
        checkOutput("t4_data_c9", bus.out_data, 32'hB000_0003);
        @(negedge clk);
        checkOutput("t4_data_c10", bus.out_data, 32'hB000_0004);
        checkOutput("t4_last_c10", 32'(bus.out_last), 32'd1);

        // Watchdog: requester 6 stalls after a non-last beat
        applyStimulus(6, 32'hC600_0001, 1'b0);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t5_sel_c1", 32'(bus.sel), 32'd6);
        checkOutput("t5_ready_c1", 32'(bus.req_ready), 32'h40);
        @(negedge clk);
        checkOutput("t5_data_c2", bus.out_data, 32'hC600_0001);
        checkOutput("t5_last_c2", 32'(bus.out_last), 32'd0);
        applyStimulus(4, 32'h4444_0001, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("t5_busy_c5", 32'(bus.busy), 32'd1);
        checkOutput("t5_err_c5", 32'(bus.err_timeout), 32'd0);
        @(negedge clk);
        checkOutput("t5_err_c6", 32'(bus.err_timeout), 32'd1);
        checkOutput("t5_busy_c6", 32'(bus.busy), 32'd0);
        checkOutput("t5_ptr7", 32'(dut.ptr_q), 32'd7);
        @(negedge clk);
        checkOutput("t5_err_c7", 32'(bus.err_timeout), 32'd0);
        checkOutput("t5_sel_c7", 32'(bus.sel), 32'd4);
        checkOutput("t5_busy_c7", 32'(bus.busy), 32'd1);
        repeat (2) @(negedge clk);

        // Reset in the middle of a three-beat packet from requester 5
        applyStimulus(5, 32'hD000_0001, 1'b0);
        applyStimulus(5, 32'hD000_0002, 1'b0);
        applyStimulus(5, 32'hD000_0003, 1'b1);
        @(posedge clk);
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t6_valid_c2", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        checkOutput("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("t6_rst_ready", 32'(bus.req_ready), 32'h00);
        checkOutput("t6_rst_sel", 32'(bus.sel), 32'd0);
        checkOutput("t6_rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("t6_rst_err", 32'(bus.err_timeout), 32'd0);
        checkOutput("t6_rst_data", bus.out_data, 32'h0);
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("t6_idle_after", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
